// File: rtl/reset_sequencer.sv
// Power-on / user / PLL-loss reset sequencer with video-mode key handling.
// Optional watchdog enabled by defining RESET_WATCHDOG_EN.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES     = 32,
  parameter int unsigned USER_MIN_CYCLES = 16,
  parameter int unsigned MODE_COUNT      = 4,
  parameter int unsigned WDT_CYCLES      = 1 << 20
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       pll_locked_i,
  input  logic       key_reset_ni,
  input  logic       key_mode_i,
  input  logic       wdt_kick_i,
  output logic       sys_reset_no,
  output logic [1:0] video_mode_o,
  output logic       mode_pulse_o,
  output logic       wdt_fired_o
);

  localparam int unsigned CntMax = (HOLD_CYCLES > USER_MIN_CYCLES) ? HOLD_CYCLES
                                                                   : USER_MIN_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] UserLast = CntW'(USER_MIN_CYCLES - 1);
  localparam logic [1:0]      ModeLast = 2'(MODE_COUNT - 1);

  typedef enum logic [1:0] {StWaitLock, StHold, StRun, StUser} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              key_mode_q;
  logic              sys_reset_q;
  logic [1:0]        video_mode_q;
  logic              mode_pulse_q;
  logic              mode_rise;
  logic              wdt_expire;

  assign mode_rise = key_mode_i & ~key_mode_q;

`ifdef RESET_WATCHDOG_EN
  localparam int unsigned WdtW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CYCLES - 1);

  logic [WdtW-1:0] wdt_cnt_q;
  logic            wdt_fired_q;

  // PLL loss outranks the watchdog, and a kick in the same cycle wins.
  assign wdt_expire = (state_q == StRun) && pll_locked_i && !wdt_kick_i &&
                      (wdt_cnt_q == WdtLast);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      if ((state_q == StRun) && pll_locked_i && key_reset_ni && !wdt_kick_i && !wdt_expire) begin
        wdt_cnt_q <= wdt_cnt_q + 1'b1;
      end else begin
        wdt_cnt_q <= '0;
      end
      if (wdt_expire) begin
        wdt_fired_q <= 1'b1;
      end
    end
  end

  assign wdt_fired_o = wdt_fired_q;
`else
  logic unused_wdt_kick;

  assign unused_wdt_kick = wdt_kick_i;
  assign wdt_expire      = 1'b0;
  assign wdt_fired_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StWaitLock;
      cnt_q        <= '0;
      key_mode_q   <= 1'b0;
      sys_reset_q  <= 1'b0;
      video_mode_q <= 2'd0;
      mode_pulse_q <= 1'b0;
    end else begin
      key_mode_q   <= key_mode_i;
      mode_pulse_q <= 1'b0;
      sys_reset_q  <= 1'b0;
      if ((state_q != StWaitLock) && !pll_locked_i) begin
        state_q <= StWaitLock;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StWaitLock: begin
            if (pll_locked_i) begin
              state_q <= StHold;
              cnt_q   <= '0;
            end
          end
          StHold: begin
            if (cnt_q == HoldLast) begin
              state_q <= StRun;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRun: begin
            if (wdt_expire || !key_reset_ni) begin
              state_q <= StUser;
              cnt_q   <= '0;
            end else begin
              // Release lags entry into RUN by one edge; assertion is immediate.
              sys_reset_q <= 1'b1;
              if (mode_rise) begin
                mode_pulse_q <= 1'b1;
                video_mode_q <= (video_mode_q == ModeLast) ? 2'd0 : video_mode_q + 2'd1;
              end
            end
          end
          StUser: begin
            if (!key_reset_ni) begin
              cnt_q <= '0;
            end else if (cnt_q == UserLast) begin
              state_q <= StRun;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign sys_reset_no = sys_reset_q;
  assign video_mode_o = video_mode_q;
  assign mode_pulse_o = mode_pulse_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (default parameters, WDT_CYCLES=64).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       key_reset_n;
  logic       key_mode;
  logic       wdt_kick;
  logic       sys_reset_n;
  logic [1:0] video_mode;
  logic       mode_pulse;
  logic       wdt_fired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES    (32),
    .USER_MIN_CYCLES(16),
    .MODE_COUNT     (4),
    .WDT_CYCLES     (64)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .pll_locked_i(pll_locked),
    .key_reset_ni(key_reset_n),
    .key_mode_i  (key_mode),
    .wdt_kick_i  (wdt_kick),
    .sys_reset_no(sys_reset_n),
    .video_mode_o(video_mode),
    .mode_pulse_o(mode_pulse),
    .wdt_fired_o (wdt_fired)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    key_reset_n = 1'b1;
    key_mode    = 1'b0;
    wdt_kick    = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sys_reset_n, video_mode, mode_pulse, wdt_fired} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got sys=%b mode=%0d pulse=%b wdt=%b want all 0",
               sys_reset_n, video_mode, mode_pulse, wdt_fired);
    end
    reset_n = 1'b1;
  endtask

  // Lock seen at edge 10; release expected from edge 43 onwards.
  task automatic test_boot;
    for (int c = 1; c <= 50; c++) begin
      if (c == 10) pll_locked = 1'b1;
      tick();
      checks++;
      if (sys_reset_n !== (c >= 43)) begin
        errors++;
        $display("FAIL boot_sys edge=%0d got %b want %b", c, sys_reset_n, (c >= 43));
      end
    end
    checks++;
    if (video_mode !== 2'd0 || mode_pulse !== 1'b0) begin
      errors++;
      $display("FAIL boot_mode got mode=%0d pulse=%b want 0/0", video_mode, mode_pulse);
    end
  endtask

  task automatic test_mode_cycle;
    logic [1:0] exp_mode [5];
    exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      key_mode = 1'b1;
      tick();
      checks++;
      if (video_mode !== exp_mode[i] || mode_pulse !== 1'b1) begin
        errors++;
        $display("FAIL mode_press%0d got mode=%0d pulse=%b want %0d/1",
                 i, video_mode, mode_pulse, exp_mode[i]);
      end
      key_mode = 1'b0;
      tick();
      checks++;
      if (video_mode !== exp_mode[i] || mode_pulse !== 1'b0) begin
        errors++;
        $display("FAIL mode_hold%0d got mode=%0d pulse=%b want %0d/0",
                 i, video_mode, mode_pulse, exp_mode[i]);
      end
    end
  endtask

  // 5-cycle press with a mode key edge inside USER that must be dropped.
  task automatic test_user_reset;
    key_reset_n = 1'b0;
    tick();
    checks++;
    if (sys_reset_n !== 1'b0) begin
      errors++;
      $display("FAIL user_assert got %b want 0", sys_reset_n);
    end
    for (int i = 1; i < 5; i++) begin
      key_mode = (i == 2);
      tick();
      checks++;
      if (sys_reset_n !== 1'b0 || video_mode !== 2'd1 || mode_pulse !== 1'b0) begin
        errors++;
        $display("FAIL user_held%0d got sys=%b mode=%0d pulse=%b want 0/1/0",
                 i, sys_reset_n, video_mode, mode_pulse);
      end
    end
    key_mode    = 1'b0;
    key_reset_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      checks++;
      if (sys_reset_n !== (k == 16)) begin
        errors++;
        $display("FAIL user_release edge=%0d got %b want %b", k, sys_reset_n, (k == 16));
      end
    end
    tick();
    checks++;
    if (video_mode !== 2'd1 || mode_pulse !== 1'b0) begin
      errors++;
      $display("FAIL user_no_defer got mode=%0d pulse=%b want 1/0", video_mode, mode_pulse);
    end
  endtask

  task automatic test_simultaneous;
    key_mode    = 1'b1;
    key_reset_n = 1'b0;
    tick();
    checks++;
    if (sys_reset_n !== 1'b0 || video_mode !== 2'd1 || mode_pulse !== 1'b0) begin
      errors++;
      $display("FAIL simul got sys=%b mode=%0d pulse=%b want 0/1/0",
               sys_reset_n, video_mode, mode_pulse);
    end
    key_mode    = 1'b0;
    key_reset_n = 1'b1;
    for (int k = 0; k <= 16; k++) tick();
    checks++;
    if (sys_reset_n !== 1'b1 || video_mode !== 2'd1) begin
      errors++;
      $display("FAIL simul_recover got sys=%b mode=%0d want 1/1", sys_reset_n, video_mode);
    end
  endtask

  task automatic test_pll_loss;
    key_mode = 1'b1;
    tick();
    checks++;
    if (video_mode !== 2'd2 || mode_pulse !== 1'b1) begin
      errors++;
      $display("FAIL pll_setup got mode=%0d pulse=%b want 2/1", video_mode, mode_pulse);
    end
    key_mode = 1'b0;
    tick();
    pll_locked = 1'b0;
    tick();
    checks++;
    if (sys_reset_n !== 1'b0 || video_mode !== 2'd2) begin
      errors++;
      $display("FAIL pll_loss got sys=%b mode=%0d want 0/2", sys_reset_n, video_mode);
    end
    for (int i = 0; i < 5; i++) begin
      key_mode = (i == 1);
      tick();
      checks++;
      if (sys_reset_n !== 1'b0 || video_mode !== 2'd2 || mode_pulse !== 1'b0) begin
        errors++;
        $display("FAIL pll_wait%0d got sys=%b mode=%0d pulse=%b want 0/2/0",
                 i, sys_reset_n, video_mode, mode_pulse);
      end
    end
    key_mode   = 1'b0;
    pll_locked = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      tick();
      if (k >= 32) begin
        checks++;
        if (sys_reset_n !== (k == 33) || video_mode !== 2'd2) begin
          errors++;
          $display("FAIL pll_relock edge=%0d got sys=%b mode=%0d want %b/2",
                   k, sys_reset_n, video_mode, (k == 33));
        end
      end
    end
  endtask

  task automatic test_async_reset_hold;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sys_reset_n, video_mode, mode_pulse, wdt_fired} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got sys=%b mode=%0d pulse=%b wdt=%b want all 0",
               sys_reset_n, video_mode, mode_pulse, wdt_fired);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k >= 33) begin
        checks++;
        if (sys_reset_n !== (k == 34) || video_mode !== 2'd0) begin
          errors++;
          $display("FAIL hold_restart edge=%0d got sys=%b mode=%0d want %b/0",
                   k, sys_reset_n, video_mode, (k == 34));
        end
      end
    end
  endtask

`ifdef RESET_WATCHDOG_EN
  task automatic test_watchdog;
    wdt_kick = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      checks++;
      if (wdt_fired !== (k == 64) || sys_reset_n !== (k < 64)) begin
        errors++;
        $display("FAIL wdt_count edge=%0d got fired=%b sys=%b want %b/%b",
                 k, wdt_fired, sys_reset_n, (k == 64), (k < 64));
      end
    end
    wdt_kick = 1'b1;
    for (int k = 65; k <= 81; k++) begin
      tick();
      checks++;
      if (sys_reset_n !== (k == 81) || wdt_fired !== 1'b1) begin
        errors++;
        $display("FAIL wdt_user edge=%0d got sys=%b fired=%b want %b/1",
                 k, sys_reset_n, wdt_fired, (k == 81));
      end
    end
  endtask
`else
  task automatic test_watchdog;
    wdt_kick = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      checks++;
      if (wdt_fired !== 1'b0 || sys_reset_n !== 1'b1) begin
        errors++;
        $display("FAIL wdt_disabled edge=%0d got fired=%b sys=%b want 0/1",
                 k, wdt_fired, sys_reset_n);
      end
    end
    wdt_kick = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_boot();
    test_mode_cycle();
    test_user_reset();
    test_simultaneous();
    test_pll_loss();
    test_async_reset_hold();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 32: cycles sys_reset_n is held low after PLL lock is first seen.
REQ-002 SHALL have parameter USER_MIN_CYCLES, default 16: cycles sys_reset_n is held low after the user reset key is released.
REQ-003 SHALL have parameter MODE_COUNT, default 4: number of video modes; legal range 2..4.
REQ-004 SHALL have parameter WDT_CYCLES, default 2^20: watchdog timeout; only used when RESET_WATCHDOG_EN is defined.
REQ-005 clk  input  1  system clock; the block's only clock, and all logic runs on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low block reset.
REQ-007 pll_locked  input  1  PLL lock status, synchronous to clk.
REQ-008 key_reset_n  input  1  debounced reset key, active low (0 = pressed).
REQ-009 key_mode  input  1  debounced mode key, active high (1 = pressed).
REQ-010 wdt_kick  input  1  watchdog kick pulse from the system; ignored unless RESET_WATCHDOG_EN is defined.
REQ-011 sys_reset_n  output  1  registered system reset, active low.
REQ-012 video_mode  output  2  current video mode index.
REQ-013 mode_pulse  output  1  one-cycle strobe marking a video_mode change.
REQ-014 wdt_fired  output  1  sticky flag: the watchdog has caused a reset.

Function
REQ-015 SHALL implement four states: WAIT_LOCK, HOLD, RUN and USER.
REQ-016 WAIT_LOCK SHALL drive sys_reset_n=0 and SHALL go to HOLD, with the counter cleared to 0, on the first cycle pll_locked=1.
REQ-017 HOLD SHALL increment the counter each cycle and SHALL go to RUN on the edge where counter==HOLD_CYCLES-1.
REQ-018 sys_reset_n SHALL be a register and SHALL be 1 exactly when the state is RUN.
REQ-019 In that register, sys_reset_n SHALL rise HOLD_CYCLES+1 edges after the first edge that samples pll_locked=1.
REQ-020 In RUN, key_reset_n=0 SHALL move the state to USER on the next edge, which also drives sys_reset_n=0.
REQ-021 USER SHALL keep the counter at 0 while key_reset_n=0.
REQ-022 After key release, USER SHALL count and SHALL return to RUN on the edge where counter==USER_MIN_CYCLES-1.
REQ-023 Re-pressing the key during the USER count SHALL restart the count from 0.
REQ-024 pll_locked=0 in any state other than WAIT_LOCK SHALL force WAIT_LOCK on the next edge and clear the counter.
REQ-025 Event priority SHALL be: PLL loss, then watchdog, then user key, then mode key.
REQ-026 key_mode SHALL be registered every cycle, and a rising edge SHALL be detected as current=1 with previous=0.
REQ-027 A key_mode rising edge in RUN SHALL advance video_mode by one, wrapping from MODE_COUNT-1 to 0.
REQ-028 A key_mode rising edge in RUN SHALL assert mode_pulse for exactly one cycle, in the same cycle video_mode updates.
REQ-029 A key_mode rising edge outside RUN SHALL be discarded and SHALL NOT be deferred.
REQ-030 A key_mode rising edge in the same cycle as a higher-priority event SHALL be discarded.
REQ-031 video_mode SHALL be preserved across user resets, PLL-loss resets and watchdog resets.
REQ-032 The counter SHALL be $clog2 of the largest of HOLD_CYCLES and USER_MIN_CYCLES bits wide, and SHALL never wrap during valid operation.

Reset
REQ-033 reset_n=0 SHALL, asynchronously, set the state to WAIT_LOCK and clear the counter, the key_mode edge register and the watchdog counter.
REQ-034 reset_n=0 SHALL, asynchronously, drive sys_reset_n=0, video_mode=0, mode_pulse=0 and wdt_fired=0.
REQ-035 reset_n asserted mid-HOLD or mid-USER SHALL abandon the count, and the full sequence SHALL restart from WAIT_LOCK.

Configuration
REQ-036 Macro RESET_WATCHDOG_EN, when defined, SHALL add a watchdog counter that increments in RUN and clears on wdt_kick=1 or on leaving RUN.
REQ-037 With RESET_WATCHDOG_EN defined, the watchdog counter reaching WDT_CYCLES-1 SHALL move the state to USER with counter=0 and key release treated as already done, and SHALL set wdt_fired=1.
REQ-038 With RESET_WATCHDOG_EN defined, wdt_fired SHALL be cleared only by reset_n.
REQ-039 Without RESET_WATCHDOG_EN, no watchdog logic SHALL be generated, wdt_kick SHALL be ignored and wdt_fired SHALL be tied to 0.

Verification
REQ-040 Bench SHALL cover boot: reset_n release, pll_locked=1 at cycle 10 -> sys_reset_n=0 through cycle 42, and 1 from cycle 43 on (HOLD_CYCLES=32).
REQ-041 Bench SHALL cover user reset: key_reset_n low for 5 cycles in RUN -> sys_reset_n low 1 edge after press, high 16 edges after release.
REQ-042 Bench SHALL cover mode cycling: 5 key_mode presses in RUN -> video_mode 1,2,3,0,1 and 5 single-cycle mode_pulse strobes.
REQ-043 Bench SHALL cover PLL loss: pll_locked=0 during RUN with video_mode=2 -> sys_reset_n=0 next edge, state WAIT_LOCK, and video_mode stays 2 through relock.
REQ-044 Bench SHALL cover simultaneous events: a key_mode edge in the same cycle as key_reset_n=0 -> USER entered, video_mode unchanged, and no mode_pulse.
REQ-045 Bench SHALL cover the watchdog (RESET_WATCHDOG_EN defined, WDT_CYCLES=64): no wdt_kick for 64 cycles in RUN -> wdt_fired=1, sys_reset_n low 16 cycles, then RUN.
